// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// op-vector bit positions, FSM state codes and HI/LO result field bounds.
package muldiv_ctrl_pkg;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE     = 2'd0;
    localparam md_state_t ST_MUL_WAIT = 2'd1;
    localparam md_state_t ST_DIV_REQ  = 2'd2;
    localparam md_state_t ST_DIV_WAIT = 2'd3;

    // {hi,lo} = {product high, product low} or {remainder, quotient}
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

    function automatic logic is_one_hot4(input logic [3:0] op);
        return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/muldiv_hilo_regs.sv
// Architectural HI/LO registers. A datapath commit takes priority over
// MTHI/MTLO; the controller never raises both in the same cycle.
module muldiv_hilo_regs
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_en,
    input  logic [63:0] commit_data,
    input  logic        mthi_en,
    input  logic        mtlo_en,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (commit_en) begin
            hi <= commit_data[HI_MSB:HI_LSB];
            lo <= commit_data[LO_MSB:LO_LSB];
        end else begin
            if (mthi_en) hi <= mt_data;
            if (mtlo_en) lo <= mt_data;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller: issues ops to the mult_div datapath,
// waits for the result, commits HI/LO and stalls EXE on HI/LO hazards.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | no op in flight; accepts ops, MTHI/MTLO, MFHI/MFLO
// ST_MUL_WAIT | multiply in flight; counter runs down to 0, then commit
// ST_DIV_REQ  | divide latched, waiting for divider tready
// ST_DIV_WAIT | divide running; commit on complete, abort at DIV_MAX
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_MAX = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_valid_in,
    input  logic [3:0]  exe_op_in,
    input  logic        exe_mthi_in,
    input  logic        exe_mtlo_in,
    input  logic        exe_mfhilo_in,
    input  logic [31:0] exe_src0_in,
    input  logic [31:0] exe_src1_in,
    input  logic        wb_ClrStpJmp_in,
    output logic [3:0]  md_op_out,
    output logic [31:0] md_in0_out,
    output logic [31:0] md_in1_out,
    input  logic [63:0] md_mult_res_in,
    input  logic [63:0] md_div_res_in,
    input  logic        md_div_complete_in,
    input  logic        md_div_tready_in,
    output logic        exe_stall_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy_out
);

    localparam int CNT_MAX = (DIV_MAX > MUL_LAT) ? DIV_MAX : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;

    logic flush;
    logic in_idle;
    logic op_legal;
    logic op_is_mul;
    logic op_is_div;
    logic issue_mul;
    logic issue_div;
    logic mul_done;
    logic div_done;
    logic div_abort;
    logic return_idle;
    logic commit_en;
    logic mthi_en;
    logic mtlo_en;
    logic hilo_access;
    logic [63:0] commit_data;

    assign flush     = wb_ClrStpJmp_in;
    assign in_idle   = (state == ST_IDLE);
    assign op_legal  = is_one_hot4(exe_op_in);
    assign op_is_mul = op_legal && (exe_op_in[OP_MULT] || exe_op_in[OP_MULTU]);
    assign op_is_div = op_legal && (exe_op_in[OP_DIV]  || exe_op_in[OP_DIVU]);

    assign issue_mul = in_idle && exe_valid_in && op_is_mul && !flush;
    assign issue_div = in_idle && exe_valid_in && op_is_div && !flush;

    assign mul_done  = (state == ST_MUL_WAIT) && (cnt == '0);
    assign div_done  = (state == ST_DIV_WAIT) && md_div_complete_in;
    assign div_abort = (state == ST_DIV_WAIT) && !md_div_complete_in
                       && (cnt == CNT_W'(DIV_MAX - 1));

    // Flush wins over a coinciding completion: nothing reaches HI/LO.
    assign return_idle = flush || mul_done || div_done || div_abort;
    assign commit_en   = !flush && (mul_done || div_done);
    assign commit_data = mul_done ? md_mult_res_in : md_div_res_in;

    assign mthi_en = in_idle && exe_valid_in && exe_mthi_in && !flush;
    assign mtlo_en = in_idle && exe_valid_in && exe_mtlo_in && !flush;

    assign hilo_access   = (exe_op_in != 4'd0) || exe_mthi_in || exe_mtlo_in
                           || exe_mfhilo_in;
    assign exe_stall_out = !flush && exe_valid_in && !in_idle && hilo_access;
    assign busy_out      = !in_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            md_op_out  <= '0;
            md_in0_out <= '0;
            md_in1_out <= '0;
        end else if (return_idle) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            md_op_out  <= '0;
            md_in0_out <= '0;
            md_in1_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_mul || issue_div) begin
                        md_op_out  <= exe_op_in;
                        md_in0_out <= exe_src0_in;
                        md_in1_out <= exe_src1_in;
                    end
                    if (issue_mul) begin
                        state <= ST_MUL_WAIT;
                        cnt   <= CNT_W'(MUL_LAT - 1);
                    end else if (issue_div) begin
                        state <= ST_DIV_REQ;
                        cnt   <= '0;
                    end
                end
                ST_MUL_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                end
                ST_DIV_REQ: begin
                    if (md_div_tready_in) begin
                        state <= ST_DIV_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_DIV_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    muldiv_hilo_regs u_hilo (
        .clk         (clk),
        .rst_n       (rst_n),
        .commit_en   (commit_en),
        .commit_data (commit_data),
        .mthi_en     (mthi_en),
        .mtlo_en     (mtlo_en),
        .mt_data     (exe_src0_in),
        .hi          (hi_out),
        .lo          (lo_out)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl with a behavioural
// mult_div datapath and an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_MAX = 40;

    logic        clk;
    logic        rst_n;
    logic        exe_valid_in;
    logic [3:0]  exe_op_in;
    logic        exe_mthi_in;
    logic        exe_mtlo_in;
    logic        exe_mfhilo_in;
    logic [31:0] exe_src0_in;
    logic [31:0] exe_src1_in;
    logic        wb_ClrStpJmp_in;
    logic [3:0]  md_op_out;
    logic [31:0] md_in0_out;
    logic [31:0] md_in1_out;
    logic [63:0] md_mult_res_in;
    logic [63:0] md_div_res_in;
    logic        md_div_complete_in;
    logic        md_div_tready_in;
    logic        exe_stall_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_MAX(DIV_MAX)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .exe_valid_in       (exe_valid_in),
        .exe_op_in          (exe_op_in),
        .exe_mthi_in        (exe_mthi_in),
        .exe_mtlo_in        (exe_mtlo_in),
        .exe_mfhilo_in      (exe_mfhilo_in),
        .exe_src0_in        (exe_src0_in),
        .exe_src1_in        (exe_src1_in),
        .wb_ClrStpJmp_in    (wb_ClrStpJmp_in),
        .md_op_out          (md_op_out),
        .md_in0_out         (md_in0_out),
        .md_in1_out         (md_in1_out),
        .md_mult_res_in     (md_mult_res_in),
        .md_div_res_in      (md_div_res_in),
        .md_div_complete_in (md_div_complete_in),
        .md_div_tready_in   (md_div_tready_in),
        .exe_stall_out      (exe_stall_out),
        .hi_out             (hi_out),
        .lo_out             (lo_out),
        .busy_out           (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: results derived from whatever operands the DUT presents.
    logic [31:0] dp_q;
    logic [31:0] dp_r;
    always_comb begin
        dp_q = '0;
        dp_r = '0;
        if (md_in1_out != 32'd0) begin
            if (md_op_out[2]) begin
                dp_q = $signed(md_in0_out) / $signed(md_in1_out);
                dp_r = $signed(md_in0_out) % $signed(md_in1_out);
            end else begin
                dp_q = md_in0_out / md_in1_out;
                dp_r = md_in0_out % md_in1_out;
            end
        end
        md_div_res_in = {dp_r, dp_q};
        if (md_op_out[0])
            md_mult_res_in = longint'($signed(md_in0_out)) * longint'($signed(md_in1_out));
        else
            md_mult_res_in = {32'd0, md_in0_out} * {32'd0, md_in1_out};
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exe();
        exe_valid_in  = 1'b0;
        exe_op_in     = 4'd0;
        exe_mthi_in   = 1'b0;
        exe_mtlo_in   = 1'b0;
        exe_mfhilo_in = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exe_valid_in = 1'b1;
        exe_op_in    = op;
        exe_src0_in  = a;
        exe_src1_in  = b;
        #1;
        chk("issue_no_stall", 64'(exe_stall_out), 64'(0));
        tick();
        exe_valid_in = 1'b0;
        exe_op_in    = 4'd0;
        chk("issue_busy", 64'(busy_out), 64'(1));
        chk("issue_op", 64'(md_op_out), 64'(op));
        chk("issue_in0", 64'(md_in0_out), 64'(a));
        chk("issue_in1", 64'(md_in1_out), 64'(b));
    endtask

    task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (op[0]) p = longint'($signed(a)) * longint'($signed(b));
        else       p = {32'd0, a} * {32'd0, b};
        issue(op, a, b);
        for (int i = 1; i < MUL_LAT; i++) begin
            tick();
            chk("mul_busy", 64'(busy_out), 64'(1));
            chk("mul_op_held", 64'(md_op_out), 64'(op));
        end
        tick();
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        chk("mul_idle", 64'(busy_out), 64'(0));
        chk("mul_op_zero", 64'(md_op_out), 64'(0));
        chk("mul_hi", 64'(hi_out), 64'(exp_hi));
        chk("mul_lo", 64'(lo_out), 64'(exp_lo));
    endtask

    // nreq: cycles tready stays low after issue; nwait: DIV_WAIT cycle on which complete rises
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int nreq, input int nwait, input logic junk_cmp,
                           input logic hold_mf);
        int sa, sb;
        logic [31:0] q, r;
        if (op[2]) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        md_div_tready_in = (nreq == 0);
        issue(op, a, b);
        if (hold_mf) begin
            exe_valid_in  = 1'b1;
            exe_mfhilo_in = 1'b1;
            #1;
        end
        for (int i = 0; i < nreq; i++) begin
            md_div_complete_in = junk_cmp;
            #1;
            chk("divreq_busy", 64'(busy_out), 64'(1));
            chk("divreq_op_held", 64'(md_op_out), 64'(op));
            tick();
        end
        md_div_complete_in = 1'b0;
        md_div_tready_in   = 1'b1;
        chk("divreq_exit_busy", 64'(busy_out), 64'(1));
        tick();
        for (int i = 1; i < nwait; i++) begin
            chk("divwait_busy", 64'(busy_out), 64'(1));
            chk("divwait_op_held", 64'(md_op_out), 64'(op));
            if (hold_mf) chk("div_mf_stall", 64'(exe_stall_out), 64'(1));
            tick();
        end
        md_div_complete_in = 1'b1;
        tick();
        md_div_complete_in = 1'b0;
        exp_hi = r;
        exp_lo = q;
        chk("div_idle", 64'(busy_out), 64'(0));
        chk("div_op_zero", 64'(md_op_out), 64'(0));
        chk("div_hi", 64'(hi_out), 64'(exp_hi));
        chk("div_lo", 64'(lo_out), 64'(exp_lo));
        if (hold_mf) begin
            chk("div_mf_released", 64'(exe_stall_out), 64'(0));
            chk("div_mf_read", 64'(lo_out), 64'(q));
            clear_exe();
        end
    endtask

    task automatic write_hi(input logic [31:0] v);
        exe_valid_in = 1'b1;
        exe_mthi_in  = 1'b1;
        exe_src0_in  = v;
        tick();
        clear_exe();
        exp_hi = v;
        chk("mthi", 64'(hi_out), 64'(exp_hi));
    endtask

    task automatic write_lo(input logic [31:0] v);
        exe_valid_in = 1'b1;
        exe_mtlo_in  = 1'b1;
        exe_src0_in  = v;
        tick();
        clear_exe();
        exp_lo = v;
        chk("mtlo", 64'(lo_out), 64'(exp_lo));
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] p;
        logic [3:0]  op;
        int n;

        clear_exe();
        exe_src0_in        = '0;
        exe_src1_in        = '0;
        wb_ClrStpJmp_in    = 1'b0;
        md_div_complete_in = 1'b0;
        md_div_tready_in   = 1'b1;
        rst_n              = 1'b1;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_hi", 64'(hi_out), 64'(0));
        chk("rst_lo", 64'(lo_out), 64'(0));
        chk("rst_op", 64'(md_op_out), 64'(0));
        chk("rst_in0", 64'(md_in0_out), 64'(0));
        chk("rst_in1", 64'(md_in1_out), 64'(0));
        chk("rst_busy", 64'(busy_out), 64'(0));
        chk("rst_stall", 64'(exe_stall_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_hi = '0;
        exp_lo = '0;

        // signed -2 * 3
        run_mul(4'b0001, 32'hFFFF_FFFE, 32'd3);
        chk("mult_dir_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mult_dir_lo", 64'(lo_out), 64'hFFFF_FFFA);

        // DIVU 100/7 with a waiting MFLO
        run_div(4'b1000, 32'd100, 32'd7, 0, 33, 1'b0, 1'b1);
        chk("divu_dir_hi", 64'(hi_out), 64'd2);
        chk("divu_dir_lo", 64'(lo_out), 64'd14);

        // DIV with tready held low; a stray complete must be ignored meanwhile
        run_div(4'b0100, 32'hFFFF_FF9C, 32'd7, 3, 5, 1'b1, 1'b0);
        chk("div_neg_hi", 64'(hi_out), 64'hFFFF_FFFE);
        chk("div_neg_lo", 64'(lo_out), 64'hFFFF_FFF2);

        // flush coinciding with divider completion
        write_hi(32'h11);
        write_lo(32'h22);
        md_div_tready_in = 1'b1;
        issue(4'b0100, 32'd50, 32'd5);
        tick();
        tick();
        tick();
        md_div_complete_in = 1'b1;
        wb_ClrStpJmp_in    = 1'b1;
        exe_valid_in       = 1'b1;
        exe_op_in          = 4'b0001;
        exe_src0_in        = 32'd9;
        exe_src1_in        = 32'd9;
        #1;
        chk("flush_no_stall", 64'(exe_stall_out), 64'(0));
        tick();
        md_div_complete_in = 1'b0;
        wb_ClrStpJmp_in    = 1'b0;
        clear_exe();
        chk("flush_idle", 64'(busy_out), 64'(0));
        chk("flush_op_zero", 64'(md_op_out), 64'(0));
        chk("flush_hi", 64'(hi_out), 64'h11);
        chk("flush_lo", 64'(lo_out), 64'h22);
        tick();
        chk("flush_req_dropped", 64'(busy_out), 64'(0));

        // MTHI/MTLO back to back, then MTLO stalled behind a multiply
        write_hi(32'hDEAD_BEEF);
        write_lo(32'h1234_5678);
        a = $urandom;
        b = $urandom;
        p = longint'($signed(a)) * longint'($signed(b));
        issue(4'b0001, a, b);
        exe_valid_in = 1'b1;
        exe_mtlo_in  = 1'b1;
        exe_src0_in  = 32'h1234_5678;
        #1;
        chk("mtlo_stall", 64'(exe_stall_out), 64'(1));
        for (int i = 1; i < MUL_LAT; i++) begin
            tick();
            chk("mtlo_stall", 64'(exe_stall_out), 64'(1));
        end
        tick();
        chk("mtlo_commit_idle", 64'(busy_out), 64'(0));
        chk("mtlo_unstalled", 64'(exe_stall_out), 64'(0));
        chk("mtlo_commit_hi", 64'(hi_out), 64'(p[63:32]));
        chk("mtlo_commit_lo", 64'(lo_out), 64'(p[31:0]));
        tick();
        clear_exe();
        exp_hi = p[63:32];
        exp_lo = 32'h1234_5678;
        chk("mtlo_override_lo", 64'(lo_out), 64'(exp_lo));
        chk("mtlo_override_hi", 64'(hi_out), 64'(exp_hi));

        // divider watchdog
        md_div_tready_in   = 1'b1;
        md_div_complete_in = 1'b0;
        issue(4'b1000, 32'd9, 32'd3);
        n = 0;
        while (busy_out && n < 200) begin
            tick();
            n++;
        end
        chk("wd_cycles", 64'(n), 64'(1 + DIV_MAX));
        chk("wd_hi", 64'(hi_out), 64'(exp_hi));
        chk("wd_lo", 64'(lo_out), 64'(exp_lo));
        run_mul(4'b0010, 32'd6, 32'd7);

        // randomized back-to-back multiplies
        for (int k = 0; k < 8; k++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'b0001 : 4'b0010;
            run_mul(op, $urandom, $urandom);
        end

        // randomized divides
        for (int k = 0; k < 6; k++) begin
            op = ($urandom_range(0, 1) == 0) ? 4'b0100 : 4'b1000;
            a  = $urandom;
            b  = $urandom_range(2, 5000);
            if (op[2] && $urandom_range(0, 1) == 1) b = ~b + 32'd1;
            run_div(op, a, b, $urandom_range(0, 3), $urandom_range(1, 20), 1'b0, 1'b0);
        end

        // MFHI in IDLE reads through without stalling
        exe_valid_in  = 1'b1;
        exe_mfhilo_in = 1'b1;
        #1;
        chk("mf_idle_no_stall", 64'(exe_stall_out), 64'(0));
        chk("mf_idle_hi", 64'(hi_out), 64'(exp_hi));
        clear_exe();

        // non-one-hot op is a NOP
        exe_valid_in = 1'b1;
        exe_op_in    = 4'b0011;
        tick();
        clear_exe();
        chk("illegal_idle", 64'(busy_out), 64'(0));
        chk("illegal_op", 64'(md_op_out), 64'(0));

        // asynchronous reset mid-multiply
        issue(4'b0001, 32'd5, 32'd5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_out), 64'(0));
        chk("arst_op", 64'(md_op_out), 64'(0));
        chk("arst_in0", 64'(md_in0_out), 64'(0));
        chk("arst_hi", 64'(hi_out), 64'(0));
        chk("arst_lo", 64'(lo_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_mul(4'b0010, 32'hFFFF_FFFF, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
